alu_cmd_sequencer: RTL and testbench

//  Initiator side of the arithmetic-unit interface. Accepts packed 8-bit ALU commands over a

---
 rtl/alu_seq_pkg.sv | 11 +
 rtl/alu_cmd_fifo.sv | 42 ++++
 rtl/alu_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state type and command/result field layout for the ALU command sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
  localparam int CMD_W   = 8;
  localparam int A_LSB   = 0;
  localparam int B_LSB   = 3;
  localparam int SEL_LSB = 6;
  localparam int OPND_W  = 3;
  localparam int SEL_W   = 2;
  localparam int RES_W   = 6;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH x W synchronous FIFO; full/empty come from the registered count only
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  // storage array, written on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
  // pointers wrap naturally; count holds still on a simultaneous push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                 (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues one at a time, waits ALU_LAT and returns results (optional op_count via ALU_OPCNT_EN)
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy
`ifdef ALU_OPCNT_EN
  ,
  output logic [7:0]        op_count
`endif
);
  localparam int CW = $clog2(ALU_LAT + 2);
  state_e r_state, w_next;
  logic [CMD_W-1:0] w_head;
  logic w_full, w_empty, w_pop, w_cap, w_done;
  logic [CW-1:0] r_cnt;
  logic [OPND_W-1:0] r_a, r_b;
  logic [SEL_W-1:0] r_sel;
  logic [RES_W-1:0] r_res;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_din   (cmd_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready = ~w_full;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign res_data  = r_res;
  assign res_valid = r_state == HOLD;
  assign busy      = ~w_empty | (r_state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state plus the issue/capture/complete strobes for the datapath
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cap  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = WAIT;
      end
      WAIT: if (r_cnt == '0) begin
        w_cap  = 1'b1;
        w_next = HOLD;
      end
      HOLD: if (res_ready) begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // operand registers hold from issue onward; wait counter counts down the ALU latency; result captured once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      if (w_pop) begin
        r_a   <= w_head[A_LSB +: OPND_W];
        r_b   <= w_head[B_LSB +: OPND_W];
        r_sel <= w_head[SEL_LSB +: SEL_W];
        r_cnt <= CW'(ALU_LAT);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_cap) r_res <= alu_result;
    end
  end

`ifdef ALU_OPCNT_EN
  logic [7:0] r_ops;
  assign op_count = r_ops;
  // completed-op counter, wraps 255 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ops <= '0;
    else if (w_done) r_ops <= r_ops + 8'd1;
  end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of reset, issue/latency, backpressure, pipelined ALU, mid-op reset and op_count
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v0, cr0, rv0, rr0, bz0, v1, cr1, rv1, rr1, bz1;
  logic [7:0] d0, d1;
  logic [2:0] a0, b0, a1, b1;
  logic [1:0] s0, s1;
  logic [5:0] res0, rd0, res1, rd1, p1, p2;
`ifdef ALU_OPCNT_EN
  logic [7:0] op0, op1;
`endif
  int checks = 0;
  int errors = 0;

  // sel 0: a*b, 1: a+b, 2: {a,b}, 3: a-b (mod 64)
  function automatic logic [5:0] alu_f(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    case (s)
      2'd0: return {3'b0, a} * {3'b0, b};
      2'd1: return {3'b0, a} + {3'b0, b};
      2'd2: return {a, b};
      default: return {3'b0, a} - {3'b0, b};
    endcase
  endfunction

  assign res0 = alu_f(a0, b0, s0);
  always @(posedge clk) begin
    p1 <= alu_f(a1, b1, s1);
    p2 <= p1;
  end
  assign res1 = p2;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(cr0), .cmd_data(d0),
    .alu_a(a0), .alu_b(b0), .alu_sel(s0), .alu_result(res0),
    .res_valid(rv0), .res_ready(rr0), .res_data(rd0), .busy(bz0)
`ifdef ALU_OPCNT_EN
    , .op_count(op0)
`endif
  );

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(cr1), .cmd_data(d1),
    .alu_a(a1), .alu_b(b1), .alu_sel(s1), .alu_result(res1),
    .res_valid(rv1), .res_ready(rr1), .res_data(rd1), .busy(bz1)
`ifdef ALU_OPCNT_EN
    , .op_count(op1)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t3_cmd [5] = '{8'h23, 8'h7F, 8'h95, 8'hD9, 8'h2E};
  int t3_exp [5] = '{12, 14, 42, 62, 30};

  initial begin
    int got;
    int n;
    v0 = 0; d0 = 0; rr0 = 0; v1 = 0; d1 = 0; rr1 = 0;
    repeat (3) tick();
    chk("rst_hold_rv", rv0, 0);
    rst_n = 1;
    tick();
    chk("rst_ready", cr0, 1);
    chk("rst_rv", rv0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_ops", {a0, b0, s0}, 0);
    chk("rst_res", rd0, 0);
    chk("rst_ready1", cr1, 1);
    chk("rst_rv1", rv1, 0);
`ifdef ALU_OPCNT_EN
    chk("rst_opcnt", op0, 0);
`endif
    // single op, ALU_LAT=0
    v0 = 1; d0 = 8'b01_010_011;
    tick();
    v0 = 0;
    chk("t2_e0_rv", rv0, 0);
    chk("t2_e0_busy", bz0, 1);
    tick();
    chk("t2_a", a0, 3);
    chk("t2_b", b0, 2);
    chk("t2_sel", s0, 1);
    chk("t2_e1_rv", rv0, 0);
    tick();
    chk("t2_e2_rv", rv0, 1);
    chk("t2_res", rd0, 5);
    rr0 = 1;
    tick();
    rr0 = 0;
    chk("t2_done_rv", rv0, 0);
    chk("t2_done_busy", bz0, 0);
    chk("t2_res_keep", rd0, 5);
    // backpressure: 1 in flight + 4 queued, 6th refused
    for (int i = 0; i < 5; i++) begin
      v0 = 1; d0 = t3_cmd[i];
      chk("t3_ready", cr0, 1);
      tick();
    end
    d0 = 8'hFF;
    chk("t3_full_ready", cr0, 0);
    chk("t3_busy", bz0, 1);
    chk("t3_hold_rv", rv0, 1);
    chk("t3_hold_res", rd0, 12);
    tick();
    tick();
    v0 = 0;
    chk("t3_full_ready2", cr0, 0);
    chk("t3_stable_rv", rv0, 1);
    chk("t3_stable_res", rd0, 12);
    rr0 = 1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (rv0) begin
        chk("t3_res", rd0, t3_exp[got]);
        got++;
      end
      tick();
    end
    rr0 = 0;
    chk("t3_count", got, 5);
    tick();
    chk("t3_drained_busy", bz0, 0);
    chk("t3_drained_rv", rv0, 0);
    // ALU_LAT=2 with pipelined ALU
    v1 = 1; d1 = 8'h35;
    tick();
    v1 = 0;
    tick();
    chk("t4_ops_e1", {a1, b1, s1}, {3'd5, 3'd6, 2'd0});
    chk("t4_rv_e1", rv1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_ops_wait", {a1, b1, s1}, {3'd5, 3'd6, 2'd0});
      chk("t4_rv_wait", rv1, 0);
    end
    tick();
    chk("t4_rv_e4", rv1, 1);
    chk("t4_res", rd1, 30);
    rr1 = 1;
    tick();
    rr1 = 0;
    chk("t4_done_rv", rv1, 0);
    // reset mid-WAIT with 3 queued
    for (int i = 0; i < 4; i++) begin
      v1 = 1; d1 = 8'h40 + 8'(i);
      tick();
    end
    v1 = 0;
    chk("t5_pre_busy", bz1, 1);
    chk("t5_pre_rv", rv1, 0);
    rst_n = 0;
    #1;
    chk("t5_rst_busy", bz1, 0);
    chk("t5_rst_ops", {a1, b1, s1}, 0);
    tick();
    rst_n = 1;
    rr1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_rv", rv1, 0);
    end
    rr1 = 0;
    chk("t5_busy", bz1, 0);
    chk("t5_ready", cr1, 1);
`ifdef ALU_OPCNT_EN
    // 257 completed ops wrap op_count to 1
    chk("t6_start", op0, 0);
    rr0 = 1; v0 = 1; d0 = 8'h7F;
    n = 0;
    for (int c = 0; c < 2000 && n < 257; c++) begin
      if (rv0) n++;
      tick();
    end
    v0 = 0;
    chk("t6_ops", n, 257);
    chk("t6_opcnt", op0, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
